// File: rtl/seven_seg_scanner_pkg.sv
// Shared constants and helpers for the seven-segment scanner.
package seven_seg_scanner_pkg;

  // Segment pattern with every segment dark (active-high form).
  localparam logic [6:0] SEG_OFF = 7'h00;

  // Hex digit to {g,f,e,d,c,b,a} in active-high form.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // Width of the digit index; a single-digit display still needs one bit.
  function automatic int unsigned idx_width(input int unsigned digits);
    return (digits <= 1) ? 1 : $clog2(digits);
  endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Core-side bus of the scanner: display data in, pin-level drive out.
interface seven_seg_scanner_if #(
  parameter int unsigned DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp_in;
  logic                load;
  logic                enable;
  logic [6:0]          seg;
  logic                dp;
  logic [DIGITS-1:0]   an;
  logic                frame_done;

  modport master (
    output value, dp_in, load, enable,
    input  seg, dp, an, frame_done
  );

  modport slave (
    input  value, dp_in, load, enable,
    output seg, dp, an, frame_done
  );
endinterface

// File: rtl/seven_seg_decoder.sv
// Combinational hex nibble to active-high segment pattern.
module seven_seg_decoder
  import seven_seg_scanner_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg_c
);

  assign seg_c = SEG_HEX[digit];

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed, double-buffered multi-digit seven-segment driver.
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned REFRESH_DIV    = 50000,
  parameter int unsigned GUARD          = 16,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1,
  parameter bit          BLANK_LEADING  = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  seven_seg_scanner_if.slave bus
);

  localparam int unsigned IDX_W = idx_width(DIGITS);
  localparam int unsigned PRE_W = $clog2(REFRESH_DIV);
  localparam int unsigned VAL_W = 4 * DIGITS;

  localparam logic [6:0]        SEG_IDLE = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic              DP_IDLE  = 1'(SEG_ACTIVE_LOW);
  localparam logic [DIGITS-1:0] AN_IDLE  = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PRE_W-1:0]  pre_cnt;
  logic [IDX_W-1:0]  idx;
  logic [VAL_W-1:0]  disp_val;
  logic [VAL_W-1:0]  pend_val;
  logic [DIGITS-1:0] disp_dp;
  logic [DIGITS-1:0] pend_dp;
  logic              pend_valid;

  logic              tick_c;
  logic              wrap_c;
  logic              guard_c;
  logic [3:0]        nib_c;
  logic              dp_sel_c;
  logic [DIGITS-1:0] an_sel_c;
  logic              blank_c;
  logic [6:0]        seg_hex_c;
  logic [6:0]        seg_lit_c;

  logic [6:0]        seg_q;
  logic              dp_q;
  logic [DIGITS-1:0] an_q;
  logic              frame_done_q;

  assign tick_c  = bus.enable && (pre_cnt == PRE_W'(REFRESH_DIV - 1));
  assign wrap_c  = tick_c && (idx == IDX_W'(DIGITS - 1));
  assign guard_c = (pre_cnt < PRE_W'(GUARD));

  // Slot prescaler and digit index; both freeze while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      idx     <= '0;
    end else if (bus.enable) begin
      if (tick_c) begin
        pre_cnt <= '0;
        idx     <= wrap_c ? '0 : idx + IDX_W'(1);
      end else begin
        pre_cnt <= pre_cnt + PRE_W'(1);
      end
    end
  end

  // Double buffer: loads park in pending, land in display only at frame wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_val   <= '0;
      disp_dp    <= '0;
      pend_val   <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
    end else if (wrap_c) begin
      if (bus.load) begin
        disp_val <= bus.value;
        disp_dp  <= bus.dp_in;
      end else if (pend_valid) begin
        disp_val <= pend_val;
        disp_dp  <= pend_dp;
      end
      pend_valid <= 1'b0;
    end else if (bus.load) begin
      pend_val   <= bus.value;
      pend_dp    <= bus.dp_in;
      pend_valid <= 1'b1;
    end
  end

  // Select the current digit's nibble, dp and anode; flag leading-zero blanking.
  always_comb begin
    logic upper_zero;
    nib_c      = 4'h0;
    dp_sel_c   = 1'b0;
    an_sel_c   = '0;
    blank_c    = 1'b0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (disp_val[4*i +: 4] == 4'h0);
      if (idx == IDX_W'(i)) begin
        nib_c       = disp_val[4*i +: 4];
        dp_sel_c    = disp_dp[i];
        an_sel_c[i] = 1'b1;
        blank_c     = (BLANK_LEADING != 1'b0) && (i > 0) && upper_zero;
      end
    end
  end

  seven_seg_decoder u_decoder (
    .digit (nib_c),
    .seg_c (seg_hex_c)
  );

  assign seg_lit_c = blank_c ? SEG_OFF : seg_hex_c;

  // Pin registers; polarity is applied only here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q        <= SEG_IDLE;
      dp_q         <= DP_IDLE;
      an_q         <= AN_IDLE;
      frame_done_q <= 1'b0;
    end else if (!bus.enable) begin
      seg_q        <= SEG_IDLE;
      dp_q         <= DP_IDLE;
      an_q         <= AN_IDLE;
      frame_done_q <= 1'b0;
    end else begin
      seg_q        <= SEG_ACTIVE_LOW ? ~seg_lit_c : seg_lit_c;
      dp_q         <= dp_sel_c ^ DP_IDLE;
      an_q         <= guard_c ? AN_IDLE : (an_sel_c ^ AN_IDLE);
      frame_done_q <= wrap_c;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner (4 digits, 4-cycle slots, guard 1).
module tb_seven_seg_scanner;

  localparam int D  = 4;
  localparam int RD = 4;
  localparam int G  = 1;
  localparam int F  = D * RD;

  logic clk;
  logic rst_n;

  seven_seg_scanner_if #(.DIGITS(D)) bus ();

  seven_seg_scanner #(
    .DIGITS(D), .REFRESH_DIV(RD), .GUARD(G),
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1), .BLANK_LEADING(1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: enabled-cycle count since reset plus shown/pending buffers.
  int          ecount;
  logic [15:0] m_val, m_pend;
  logic [3:0]  m_dp, m_pdp;
  bit          m_pv;

  // Expected pin values for the most recent step.
  logic [6:0] e_seg;
  logic       e_dp;
  logic [3:0] e_an;
  logic       e_fd;
  int         e_digit;
  bit         e_lit;

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic [3:0][6:0] seg;    // seg[d] = expected pin pattern of digit d
    logic [3:0]      dp_out; // dp_out[d] = expected dp pin of digit d
  } vec_t;

  vec_t tbl [5];

  function automatic logic [6:0] hex_ah(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F; 4'h1: return 7'h06; 4'h2: return 7'h5B; 4'h3: return 7'h4F;
      4'h4: return 7'h66; 4'h5: return 7'h6D; 4'h6: return 7'h7D; 4'h7: return 7'h07;
      4'h8: return 7'h7F; 4'h9: return 7'h6F; 4'hA: return 7'h77; 4'hB: return 7'h7C;
      4'hC: return 7'h39; 4'hD: return 7'h5E; 4'hE: return 7'h79; default: return 7'h71;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ecount = 0;
    m_val  = '0; m_pend = '0;
    m_dp   = '0; m_pdp  = '0;
    m_pv   = 1'b0;
  endtask

  // One clock: predict pins from model state and current inputs, advance model, compare.
  task automatic step();
    int pos, d, ph;
    logic [3:0] nib;
    bit blank;
    pos = ecount % F;
    d   = pos / RD;
    ph  = pos % RD;
    if (!bus.enable) begin
      e_seg = 7'h7F; e_dp = 1'b1; e_an = 4'hF; e_fd = 1'b0;
      e_lit = 1'b0;  e_digit = -1;
    end else begin
      nib     = m_val[4*d +: 4];
      blank   = (d > 0) && ((m_val >> (4*d)) == 16'h0);
      e_seg   = blank ? 7'h7F : ~hex_ah(nib);
      e_dp    = ~m_dp[d];
      e_lit   = (ph >= G);
      e_an    = e_lit ? ~(4'b0001 << d) : 4'hF;
      e_fd    = (pos == F - 1);
      e_digit = d;
    end
    if (bus.enable && pos == F - 1) begin
      if (bus.load) begin
        m_val = bus.value; m_dp = bus.dp_in;
      end else if (m_pv) begin
        m_val = m_pend; m_dp = m_pdp;
      end
      m_pv = 1'b0;
    end else if (bus.load) begin
      m_pend = bus.value; m_pdp = bus.dp_in; m_pv = 1'b1;
    end
    if (bus.enable) ecount++;
    @(posedge clk); #1;
    check("seg", 32'(bus.seg), 32'(e_seg));
    check("dp", 32'(bus.dp), 32'(e_dp));
    check("an", 32'(bus.an), 32'(e_an));
    check("frame_done", 32'(bus.frame_done), 32'(e_fd));
  endtask

  // Advance until the model's next pre-edge frame position equals target.
  task automatic goto_pos(input int target);
    for (int i = 0; i <= F && (ecount % F) != target; i++) step();
  endtask

  task automatic load_once(input logic [15:0] v, input logic [3:0] dpv);
    bus.value = v; bus.dp_in = dpv; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
  endtask

  initial begin
    int fd_cnt, last_fd;

    tbl[0] = '{16'h12AF, 4'b0000, {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1111};
    tbl[1] = '{16'h0005, 4'b0100, {7'h7F, 7'h7F, 7'h7F, 7'h12}, 4'b1011};
    tbl[2] = '{16'h0000, 4'b0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
    tbl[3] = '{16'h0300, 4'b1001, {7'h7F, 7'h30, 7'h40, 7'h40}, 4'b0110};
    tbl[4] = '{16'h8C0E, 4'b0010, {7'h00, 7'h46, 7'h40, 7'h06}, 4'b1101};

    rst_n = 1'b0;
    bus.value = '0; bus.dp_in = '0; bus.load = 1'b0; bus.enable = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_seg", 32'(bus.seg), 32'h7F);
    check("reset_dp", 32'(bus.dp), 32'h1);
    check("reset_an", 32'(bus.an), 32'hF);
    check("reset_frame_done", 32'(bus.frame_done), 32'h0);
    rst_n = 1'b1;

    // Table vectors: load, let it land, then check every lit digit of a later frame.
    for (int v = 0; v < 5; v++) begin
      load_once(tbl[v].value, tbl[v].dp);
      for (int k = 0; k < 3 * F; k++) begin
        step();
        if (k >= 2 * F && e_lit) begin
          check($sformatf("tbl%0d_seg_d%0d", v, e_digit), 32'(bus.seg), 32'(tbl[v].seg[e_digit]));
          check($sformatf("tbl%0d_dp_d%0d", v, e_digit), 32'(bus.dp), 32'(tbl[v].dp_out[e_digit]));
        end
      end
    end

    // Two loads during digit 1's slot: old value for the rest of this frame, last one wins next.
    goto_pos(RD);
    load_once(16'h1111, 4'b0000);
    load_once(16'h2222, 4'b0000);
    goto_pos(0);
    for (int k = 0; k < F; k++) begin
      step();
      if (e_lit) check("midload_seg", 32'(bus.seg), 32'h24);
    end

    // Load on the wrap tick goes straight to the display.
    goto_pos(F - 1);
    load_once(16'h3333, 4'b0000);
    for (int k = 0; k < RD; k++) begin
      step();
      if (e_lit) check("wrapload_seg", 32'(bus.seg), 32'h30);
    end

    // Disable for 10 cycles in the middle of slot 2, then resume.
    goto_pos(2 * RD + 2);
    bus.enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("disabled_an", 32'(bus.an), 32'hF);
      check("disabled_fd", 32'(bus.frame_done), 32'h0);
    end
    bus.enable = 1'b1;
    step();
    step();
    check("resume_an", 32'(bus.an), 32'hB);

    // Asynchronous reset with a pending load outstanding.
    goto_pos(RD + 2);
    load_once(16'h7777, 4'b1111);
    #3 rst_n = 1'b0;
    #1;
    check("rst_async_seg", 32'(bus.seg), 32'h7F);
    check("rst_async_dp", 32'(bus.dp), 32'h1);
    check("rst_async_an", 32'(bus.an), 32'hF);
    check("rst_async_fd", 32'(bus.frame_done), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 2 * F; k++) begin
      step();
      if (e_lit && e_digit == 0) check("post_rst_d0", 32'(bus.seg), 32'h40);
    end

    // frame_done: three single-cycle pulses, one per frame.
    fd_cnt  = 0;
    last_fd = -1;
    for (int k = 0; k < 3 * F; k++) begin
      step();
      if (bus.frame_done) begin
        fd_cnt++;
        if (last_fd >= 0) check("fd_spacing", 32'(k - last_fd), 32'(F));
        last_fd = k;
      end
    end
    check("fd_count", 32'(fd_cnt), 32'd3);

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      bus.enable = ($urandom_range(0, 9) != 0);
      bus.load   = ($urandom_range(0, 5) == 0);
      bus.value  = 16'($urandom);
      bus.dp_in  = 4'($urandom);
      step();
    end
    bus.load = 1'b0;
    bus.enable = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
